// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: receiver lock states, default 640x480
// timing constants and saturating counter helpers.
package vga_timing_pkg;

    localparam int H_TOTAL_DEF  = 800;
    localparam int V_TOTAL_DEF  = 525;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int CNT_W = 10;
    localparam int ERR_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [ERR_W-1:0] err_t;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic        valid;
        logic [23:0] rgb;
        logic        h_fall;
        logic        v_fall;
        logic        valid_fall;
    } sync_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    function automatic err_t sat_inc_err(input err_t v);
        return (v == '1) ? v : v + err_t'(1);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Input registers for the VGA receiver: one sample stage, a second copy
// for edge detection, and falling-edge strobes for the sync/enable lines.
module vga_sync_edge
    import vga_timing_pkg::*;
(
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [23:0] rgb,
    output sync_t       edges
);

    logic        hsync_s1;
    logic        hsync_s2;
    logic        vsync_s1;
    logic        vsync_s2;
    logic        valid_s1;
    logic        valid_s2;
    logic [23:0] rgb_s1;

    // Syncs idle high, so a reset value of 1 never fakes a falling edge.
    always_ff @(posedge pclk) begin
        if (reset) begin
            hsync_s1 <= 1'b1;
            hsync_s2 <= 1'b1;
            vsync_s1 <= 1'b1;
            vsync_s2 <= 1'b1;
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            rgb_s1   <= '0;
        end else begin
            hsync_s1 <= hsync;
            hsync_s2 <= hsync_s1;
            vsync_s1 <= vsync;
            vsync_s2 <= vsync_s1;
            valid_s1 <= valid;
            valid_s2 <= valid_s1;
            rgb_s1   <= rgb;
        end
    end

    always_comb begin
        edges.valid      = valid_s1;
        edges.rgb        = rgb_s1;
        edges.h_fall     = hsync_s2 & ~hsync_s1;
        edges.v_fall     = vsync_s2 & ~vsync_s1;
        edges.valid_fall = valid_s2 & ~valid_s1;
    end

endmodule

// File: rtl/vga_rx_capture.sv
// VGA receiver: measures line/frame timing, locks to the expected raster
// and emits addressed pixel writes for the active area while locked.
module vga_rx_capture
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic [23:0] pix_data,
    output logic        pix_we,
    output logic        frame_start,
    output logic        locked,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic [7:0]  err_cnt
);

    localparam logic [10:0] H_TOTAL_L  = 11'(H_TOTAL);
    localparam cnt_t        V_TOTAL_L  = cnt_t'(V_TOTAL);
    localparam cnt_t        H_ACTIVE_L = cnt_t'(H_ACTIVE);
    localparam cnt_t        V_ACTIVE_L = cnt_t'(V_ACTIVE);

    sync_t       edges;
    rx_state_t   state;
    rx_state_t   state_nx;
    cnt_t        hcnt;
    cnt_t        lcnt;
    cnt_t        xcnt;
    cnt_t        ycnt;
    logic        seen;
    logic [10:0] hlen;
    logic        line_ok;
    logic        frame_ok;
    logic        lock_lost;
    cnt_t        x_base;
    cnt_t        y_step;
    cnt_t        y_base;
    logic        wr_nx;
    logic        fs_nx;

    vga_sync_edge u_sync (
        .pclk  (pclk),
        .reset (reset),
        .hsync (hsync),
        .vsync (vsync),
        .valid (valid),
        .rgb   ({vga_r, vga_g, vga_b}),
        .edges (edges)
    );

    assign hlen     = {1'b0, hcnt} + 11'd1;
    assign line_ok  = (hlen == H_TOTAL_L);
    assign frame_ok = (lcnt == V_TOTAL_L);

    always_ff @(posedge pclk) begin
        if (reset) begin
            state <= SEARCH;
        end else begin
            state <= state_nx;
        end
    end

    // A bad line length outranks any vsync decision in the same cycle.
    always_comb begin
        state_nx  = state;
        lock_lost = 1'b0;
        unique case (state)
            SEARCH: begin
                if (edges.v_fall) begin
                    state_nx = MEASURE;
                end
            end
            MEASURE: begin
                if (edges.h_fall && !line_ok) begin
                    state_nx = SEARCH;
                end else if (edges.v_fall) begin
                    state_nx = frame_ok ? LOCKED : SEARCH;
                end
            end
            LOCKED: begin
                if ((edges.h_fall && !line_ok) ||
                    (edges.v_fall && !frame_ok)) begin
                    state_nx  = SEARCH;
                    lock_lost = 1'b1;
                end
            end
            default: begin
                state_nx = SEARCH;
            end
        endcase
    end

    always_comb begin
        x_base = edges.h_fall ? '0 : xcnt;
        y_step = (edges.h_fall && seen) ? sat_inc(ycnt) : ycnt;
        y_base = edges.v_fall ? '0 : y_step;
        wr_nx  = edges.valid && (state == LOCKED) &&
                 (x_base < H_ACTIVE_L) && (y_base < V_ACTIVE_L);
        fs_nx  = edges.v_fall && (state_nx == LOCKED);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            hcnt <= '0;
            lcnt <= '0;
            xcnt <= '0;
            ycnt <= '0;
            seen <= 1'b0;
        end else begin
            hcnt <= edges.h_fall ? '0 : sat_inc(hcnt);
            if (edges.v_fall) begin
                lcnt <= edges.h_fall ? cnt_t'(1) : '0;
            end else if (edges.h_fall) begin
                lcnt <= sat_inc(lcnt);
            end
            xcnt <= edges.valid ? sat_inc(x_base) : x_base;
            ycnt <= y_base;
            if (edges.h_fall) begin
                seen <= edges.valid;
            end else begin
                seen <= seen | edges.valid | edges.valid_fall;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            h_addr      <= '0;
            v_addr      <= '0;
            pix_data    <= '0;
            pix_we      <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            err_cnt     <= '0;
        end else begin
            pix_we      <= wr_nx;
            frame_start <= fs_nx;
            locked      <= (state_nx == LOCKED);
            if (wr_nx) begin
                h_addr   <= x_base;
                v_addr   <= y_base;
                pix_data <= edges.rgb;
            end
            if (edges.h_fall) begin
                line_len <= hlen[10] ? '1 : hlen[9:0];
            end
            if (edges.v_fall) begin
                frame_lines <= lcnt;
            end
            if (lock_lost) begin
                err_cnt <= sat_inc_err(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_capture.sv
// Self-checking bench for vga_rx_capture on a scaled-down 16x8 raster
// with a 10x5 active window and a queue scoreboard of expected writes.
module tb_vga_rx_capture;

    localparam int HT   = 16;
    localparam int VT   = 8;
    localparam int HA   = 10;
    localparam int VA   = 5;
    localparam int HS_W = 2;
    localparam int HA0  = 3;
    localparam int VA0  = 2;

    logic        pclk  = 1'b0;
    logic        reset = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  vga_r = '0;
    logic [7:0]  vga_g = '0;
    logic [7:0]  vga_b = '0;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic [23:0] pix_data;
    logic        pix_we;
    logic        frame_start;
    logic        locked;
    logic [9:0]  line_len;
    logic [9:0]  frame_lines;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rise_step = -1;
    int drop_step = -1;
    int fs_step = -1;
    int vf_step = -1;
    int hf_line[VT];
    logic [9:0] first_h, first_v, last_h, last_v;
    logic locked_prev = 1'b0;
    logic [43:0] exp_q[$];

    vga_rx_capture #(
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .H_ACTIVE (HA),
        .V_ACTIVE (VA)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .valid       (valid),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .h_addr      (h_addr),
        .v_addr      (v_addr),
        .pix_data    (pix_data),
        .pix_we      (pix_we),
        .frame_start (frame_start),
        .locked      (locked),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .err_cnt     (err_cnt)
    );

    always #5 pclk = ~pclk;

    function automatic logic [23:0] pix(input int f, input int x, input int y);
        logic [7:0] r, g, b;
        r = 8'(x * 7 + f);
        g = 8'(y * 13 + f * 3);
        b = 8'(x ^ y ^ (f * 5));
        return {r, g, b};
    endfunction

    // One pixel clock: drive, push any expected write, then score outputs.
    task automatic step(input logic hs, input logic vs, input logic vl,
                        input logic [23:0] c, input bit ew,
                        input int ex, input int ey);
        logic [43:0] got;
        logic [43:0] e;
        @(posedge pclk);
        #1;
        cyc++;
        hsync = hs;
        vsync = vs;
        valid = vl;
        {vga_r, vga_g, vga_b} = c;
        if (ew) exp_q.push_back({10'(ex), 10'(ey), c});
        @(negedge pclk);
        if (pix_we) begin
            got = {h_addr, v_addr, pix_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write step=%0d got=%h required=none",
                         cyc, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL write_data step=%0d got=%h required=%h",
                             cyc, got, e);
                end
            end
            if (wr_cnt == 0) begin
                first_h = h_addr;
                first_v = v_addr;
            end
            last_h = h_addr;
            last_v = v_addr;
            wr_cnt++;
        end
        if (locked === 1'b1 && !locked_prev) rise_step = cyc;
        if (locked === 1'b0 && locked_prev) drop_step = cyc;
        locked_prev = (locked === 1'b1);
        if (frame_start === 1'b1) fs_step = cyc;
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 0, 0);
    endtask

    // Streams nlines lines; writes expected only for lines below exp_until.
    task automatic drive_frame(input int fid, input int exp_until,
                               input int short_y, input int wide_y,
                               input int nlines);
        int len, na, ax, ay;
        bit act, ew;
        for (int y = 0; y < nlines; y++) begin
            len = (y == short_y) ? HT - 1 : HT;
            na  = (y == wide_y) ? HA + 1 : HA;
            for (int x = 0; x < len; x++) begin
                act = (y >= VA0) && (y < VA0 + VA) &&
                      (x >= HA0) && (x < HA0 + na);
                ax  = x - HA0;
                ay  = y - VA0;
                ew  = act && (y < exp_until) && (ax < HA);
                step(x >= HS_W, y != 0, act,
                     act ? pix(fid, ax, ay) : 24'h0, ew, ax, ay);
                if (x == 0) hf_line[y] = cyc;
                if (x == 0 && y == 0) vf_step = cyc;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) idle();
        checks++;
        if ({h_addr, v_addr, pix_data, pix_we, frame_start, locked,
             line_len, frame_lines, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%h/%h/%b/%b/%b/%h/%h/%h required=0",
                     h_addr, v_addr, pix_data, pix_we, frame_start, locked,
                     line_len, frame_lines, err_cnt);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_locked got=%b required=0", locked);
        end
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        drive_frame(1, 0, -1, -1, VT);
        drive_frame(2, VT, -1, -1, VT);
        checks++;
        if (rise_step !== vf_step + 2) begin
            errors++;
            $display("FAIL lock_latency got=%0d required=%0d", rise_step, vf_step + 2);
        end
        wr_cnt = 0;
        drive_frame(3, VT, -1, -1, VT);
        checks++;
        if (wr_cnt !== HA * VA) begin
            errors++;
            $display("FAIL frame3_writes got=%0d required=%0d", wr_cnt, HA * VA);
        end
        checks++;
        if ({first_h, first_v} !== {10'd0, 10'd0}) begin
            errors++;
            $display("FAIL first_write got=(%0d,%0d) required=(0,0)", first_h, first_v);
        end
        checks++;
        if ({last_h, last_v} !== {10'(HA - 1), 10'(VA - 1)}) begin
            errors++;
            $display("FAIL last_write got=(%0d,%0d) required=(%0d,%0d)",
                     last_h, last_v, HA - 1, VA - 1);
        end
        checks++;
        if (line_len !== 10'(HT)) begin
            errors++;
            $display("FAIL line_len got=%0d required=%0d", line_len, HT);
        end
        checks++;
        if (frame_lines !== 10'(VT)) begin
            errors++;
            $display("FAIL frame_lines got=%0d required=%0d", frame_lines, VT);
        end
        checks++;
        if (fs_step !== vf_step + 2) begin
            errors++;
            $display("FAIL frame_start got=%0d required=%0d", fs_step, vf_step + 2);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL nominal_missing got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_wide_line();
        wr_cnt = 0;
        drive_frame(4, VT, -1, 4, VT);
        checks++;
        if (wr_cnt !== HA * VA) begin
            errors++;
            $display("FAIL wide_writes got=%0d required=%0d", wr_cnt, HA * VA);
        end
        checks++;
        if ({locked, err_cnt} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL wide_no_error got=%b/%0d required=1/0", locked, err_cnt);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL wide_missing got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_short_line();
        drive_frame(5, 4, 3, -1, VT);
        checks++;
        if (drop_step !== hf_line[4] + 2) begin
            errors++;
            $display("FAIL drop_latency got=%0d required=%0d", drop_step, hf_line[4] + 2);
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL err_after_short got=%0d required=1", err_cnt);
        end
        wr_cnt = 0;
        drive_frame(6, 0, -1, -1, VT);
        checks++;
        if ({locked, wr_cnt} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL measure_frame got=%b/%0d required=0/0", locked, wr_cnt);
        end
        drive_frame(7, VT, -1, -1, VT);
        checks++;
        if (rise_step !== vf_step + 2) begin
            errors++;
            $display("FAIL relock got=%0d required=%0d", rise_step, vf_step + 2);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL relock_missing got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_midline();
        drive_frame(8, VT, -1, -1, 3);
        step(1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 0, 0);
        reset = 1'b1;
        idle();
        checks++;
        if ({h_addr, v_addr, pix_data, pix_we, frame_start, locked,
             line_len, frame_lines, err_cnt} !== '0) begin
            errors++;
            $display("FAIL midline_reset got=%h/%h/%h/%b/%b/%b/%h/%h/%h required=0",
                     h_addr, v_addr, pix_data, pix_we, frame_start, locked,
                     line_len, frame_lines, err_cnt);
        end
        idle();
        reset = 1'b0;
        wr_cnt = 0;
        drive_frame(9, 0, -1, -1, VT);
        checks++;
        if (wr_cnt !== 0) begin
            errors++;
            $display("FAIL post_reset_early got=%0d required=0", wr_cnt);
        end
        drive_frame(10, VT, -1, -1, VT);
        checks++;
        if (wr_cnt !== HA * VA) begin
            errors++;
            $display("FAIL post_reset_writes got=%0d required=%0d", wr_cnt, HA * VA);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL post_reset_missing got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_err_saturation();
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        for (int ev = 0; ev < 300; ev++) begin
            drive_frame(100, 0, -1, -1, VT);
            drive_frame(101, 0, 0, -1, 2);
            if (ev == 253) begin
                checks++;
                if (err_cnt !== 8'd254) begin
                    errors++;
                    $display("FAIL err_254 got=%0d required=254", err_cnt);
                end
            end
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL err_saturate got=%0d required=255", err_cnt);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL err_unlocked got=%b required=0", locked);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wide_line();
        test_short_line();
        test_reset_midline();
        test_err_saturation();
        repeat (4) idle();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL final_queue got=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
